// File: rtl/shifter_pkg.sv
// Shared constants for the barrel shifter datapath: direction encodings
// and the default data width used when the top is instantiated bare.
package shifter_pkg;

  localparam int DEFAULT_WIDTH = 8;

  localparam logic DIR_LEFT  = 1'b1;
  localparam logic DIR_RIGHT = 1'b0;

endpackage : shifter_pkg

// File: rtl/barrel_stage.sv
// One stage of the barrel shifter mux network: a logical right shift by a
// fixed power-of-two amount, or a straight pass-through when not enabled.
module barrel_stage #(
  parameter int WIDTH = 8,
  parameter int SHIFT = 1
) (
  input  logic [WIDTH-1:0] d,
  input  logic             en,
  output logic [WIDTH-1:0] q
);

  // Select between the shifted word and the untouched word for this stage
  always_comb begin
    q = d;
    if (en) begin
      q = d >> SHIFT;
    end
  end

endmodule : barrel_stage

// File: rtl/barrel_shifter.sv
// Registered logical barrel shifter. The stage chain only ever shifts
// right; a left shift is done by bit-reversing the word on the way in and
// again on the way out. The result lands in one output register, so the
// latency is exactly one clock.
module barrel_shifter
  import shifter_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [WIDTH-1:0]         In,
  input  logic                     Lr,
  input  logic [$clog2(WIDTH)-1:0] n,
  input  logic                     in_valid,
  output logic [WIDTH-1:0]         Out,
  output logic                     out_valid
);

  localparam int SHW = $clog2(WIDTH);

  logic [WIDTH-1:0]          reversedIn;
  logic [WIDTH-1:0]          reversedResult;
  logic [WIDTH-1:0]          shifted;
  logic [SHW:0][WIDTH-1:0]   stageData;

  logic [WIDTH-1:0] outQ, outD;
  logic             validQ, validD;

  // Mirror the input word so that a left shift becomes a right shift
  always_comb begin
    reversedIn = '0;
    for (int i = 0; i < WIDTH; i++) begin
      reversedIn[i] = In[WIDTH-1-i];
    end
  end

  assign stageData[0] = (Lr == DIR_LEFT) ? reversedIn : In;

  // Stage k shifts right by 2^k when bit k of the shift amount is set
  for (genvar k = 0; k < SHW; k++) begin : gStage
    barrel_stage #(
      .WIDTH (WIDTH),
      .SHIFT (1 << k)
    ) uStage (
      .d  (stageData[k]),
      .en (n[k]),
      .q  (stageData[k+1])
    );
  end

  // Undo the input mirroring so a left shift ends up pointing toward the MSB
  always_comb begin
    reversedResult = '0;
    for (int i = 0; i < WIDTH; i++) begin
      reversedResult[i] = stageData[SHW][WIDTH-1-i];
    end
  end

  assign shifted = (Lr == DIR_LEFT) ? reversedResult : stageData[SHW];

  // Capture a new result only when the inputs are qualified, otherwise hold
  always_comb begin
    outD   = outQ;
    validD = in_valid;
    if (in_valid) begin
      outD = shifted;
    end
  end

  // Output register; reset clears both the result and its valid flag at once
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      outQ   <= '0;
      validQ <= 1'b0;
    end else begin
      outQ   <= outD;
      validQ <= validD;
    end
  end

  assign Out       = outQ;
  assign out_valid = validQ;

endmodule : barrel_shifter

// File: tb/tb_barrel_shifter.sv
// Self-checking bench for barrel_shifter at WIDTH=8: a table of directed
// vectors with hand-computed results, a back-to-back random run against a
// shift-operator reference, and hand-written reset and hold sequences.
module tb_barrel_shifter;

  localparam int WIDTH = 8;

  typedef struct {
    logic [7:0] dataIn;
    logic       dir;
    logic [2:0] amt;
    logic [7:0] expOut;
  } vector_t;

  logic       clk;
  logic       rst_n;
  logic [7:0] In;
  logic       Lr;
  logic [2:0] n;
  logic       in_valid;
  logic [7:0] Out;
  logic       out_valid;

  int testsRun;
  int testsFailed;

  vector_t vectors [14];

  barrel_shifter #(
    .WIDTH (WIDTH)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .In        (In),
    .Lr        (Lr),
    .n         (n),
    .in_valid  (in_valid),
    .Out       (Out),
    .out_valid (out_valid)
  );

  // Free-running 10 ns clock
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Safety net so the run always ends even if something stalls
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  // Drive one set of inputs with blocking assignments
  task automatic applyStimulus(input logic [7:0] dataIn, input logic dir,
                               input logic [2:0] amt, input logic valid);
    In       = dataIn;
    Lr       = dir;
    n        = amt;
    in_valid = valid;
  endtask

  // Compare both outputs against expected values and report any difference
  task automatic checkOutput(input string name, input logic [7:0] expOut,
                             input logic expValid);
    testsRun++;
    if (Out !== expOut) begin
      testsFailed++;
      $display("[TB] FAIL %s Out: got %b, expected %b", name, Out, expOut);
    end
    testsRun++;
    if (out_valid !== expValid) begin
      testsFailed++;
      $display("[TB] FAIL %s out_valid: got %b, expected %b", name, out_valid, expValid);
    end
  endtask

  // Reference behaviour written directly from the shift operators
  function automatic logic [7:0] refShift(input logic [7:0] dataIn,
                                          input logic dir, input logic [2:0] amt);
    return dir ? (dataIn << amt) : (dataIn >> amt);
  endfunction

  // Main test sequence
  initial begin
    logic [7:0] lastOut;
    logic [7:0] rIn;
    logic       rDir;
    logic [2:0] rAmt;

    testsRun    = 0;
    testsFailed = 0;

    vectors[0]  = '{8'b11011001, 1'b1, 3'd3, 8'b11001000};
    vectors[1]  = '{8'b11011001, 1'b0, 3'd4, 8'b00001101};
    vectors[2]  = '{8'b11011001, 1'b1, 3'd5, 8'b00100000};
    vectors[3]  = '{8'b11011001, 1'b0, 3'd7, 8'b00000001};
    vectors[4]  = '{8'b11011001, 1'b1, 3'd0, 8'b11011001};
    vectors[5]  = '{8'b11011001, 1'b0, 3'd0, 8'b11011001};
    vectors[6]  = '{8'b11011001, 1'b1, 3'd7, 8'b10000000};
    vectors[7]  = '{8'b11011001, 1'b0, 3'd6, 8'b00000011};
    vectors[8]  = '{8'b10000000, 1'b0, 3'd7, 8'b00000001};
    vectors[9]  = '{8'b00000001, 1'b1, 3'd7, 8'b10000000};
    vectors[10] = '{8'b11111111, 1'b1, 3'd1, 8'b11111110};
    vectors[11] = '{8'b11111111, 1'b0, 3'd1, 8'b01111111};
    vectors[12] = '{8'b10101010, 1'b0, 3'd3, 8'b00010101};
    vectors[13] = '{8'b01010101, 1'b1, 3'd2, 8'b01010100};

    rst_n = 1'b1;
    applyStimulus(8'h00, 1'b0, 3'd0, 1'b0);

    // Load a nonzero result so the asynchronous clear is observable
    @(negedge clk);
    applyStimulus(8'b11111111, 1'b1, 3'd0, 1'b1);
    @(posedge clk);
    #1;
    checkOutput("preload", 8'b11111111, 1'b1);
    applyStimulus(8'h00, 1'b0, 3'd0, 1'b0);

    #1;
    rst_n = 1'b0;
    #1;
    checkOutput("async_reset", 8'h00, 1'b0);

    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 2; i++) begin
      @(posedge clk);
      #1;
      checkOutput("post_reset_idle", 8'h00, 1'b0);
    end

    // Directed table applied back-to-back
    @(negedge clk);
    for (int i = 0; i < 14; i++) begin
      applyStimulus(vectors[i].dataIn, vectors[i].dir, vectors[i].amt, 1'b1);
      @(posedge clk);
      #1;
      checkOutput($sformatf("vec%0d", i), vectors[i].expOut, 1'b1);
    end

    // Sixteen random vectors with in_valid held high every cycle
    lastOut = '0;
    for (int i = 0; i < 16; i++) begin
      rIn  = 8'($urandom);
      rDir = 1'($urandom);
      rAmt = 3'($urandom_range(0, 7));
      applyStimulus(rIn, rDir, rAmt, 1'b1);
      lastOut = refShift(rIn, rDir, rAmt);
      @(posedge clk);
      #1;
      checkOutput($sformatf("rand%0d", i), lastOut, 1'b1);
    end

    // Drop in_valid with unknown controls; the result must hold unchanged
    applyStimulus(8'hxx, 1'bx, 3'bxxx, 1'b0);
    for (int i = 0; i < 2; i++) begin
      @(posedge clk);
      #1;
      checkOutput("hold", lastOut, 1'b0);
    end

    // Reset between two valid inputs drops the in-flight word
    @(negedge clk);
    applyStimulus(8'b00110011, 1'b1, 3'd1, 1'b1);
    @(posedge clk);
    #1;
    checkOutput("midstream_a", 8'b01100110, 1'b1);
    applyStimulus(8'b11110000, 1'b0, 3'd2, 1'b1);
    #1;
    rst_n = 1'b0;
    #1;
    checkOutput("midstream_reset", 8'h00, 1'b0);
    @(posedge clk);
    #1;
    checkOutput("reset_held", 8'h00, 1'b0);
    @(negedge clk);
    applyStimulus(8'h00, 1'b0, 3'd0, 1'b0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    checkOutput("no_stale", 8'h00, 1'b0);

    // Normal operation resumes after the reset
    applyStimulus(8'b11110000, 1'b0, 3'd2, 1'b1);
    @(posedge clk);
    #1;
    checkOutput("recover", 8'b00111100, 1'b1);
    applyStimulus(8'h00, 1'b0, 3'd0, 1'b0);

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule : tb_barrel_shifter
